stage_sequencer: RTL and testbench

Controller for the start/done handshake used by the LED counter chain. It issues one-cycle `start` pulses to each counter stage in turn and waits for each stage's `done` pulse before launching the next. It loops over the stages for a programmed number of passes and muxes the active stage's value onto the LED bus. It replaces the hand-wired start/transition/LED glue logic, and it supervises the chain with a watchdog and stray-`done` detection.

---
 rtl/stage_sequencer.sv | 137 +++++++++++++
 tb/tb_stage_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_sequencer.sv
// stage_sequencer
// Drives the start/done handshake of the LED counter chain. Each stage gets a
// one-cycle start pulse and the next stage launches only after the current
// stage reports done. The chain is looped for a programmed number of passes.
// A watchdog and stray-done detection raise a sticky error flag.
module stage_sequencer #(
  parameter int STAGES         = 2,
  parameter int VALUE_WIDTH    = 4,
  parameter int REPEAT_COUNT   = 0,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int IDX_W         = (STAGES > 1) ? $clog2(STAGES) : 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          go,
  input  logic                          halt,
  output logic [STAGES-1:0]             stage_start,
  input  logic [STAGES-1:0]             stage_done,
  input  logic [STAGES-1:0]             stage_enabled,
  input  logic [STAGES*VALUE_WIDTH-1:0] stage_value,
  output logic [VALUE_WIDTH-1:0]        led,
  output logic                          active,
  output logic [IDX_W-1:0]              stage_index,
  output logic [7:0]                    pass_count,
  output logic                          error,
  output logic                          seq_done
);

  // The watchdog must be able to hold TIMEOUT_CYCLES; keep at least one bit
  // so the counter still exists when the watchdog is disabled.
  localparam int WD_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2
  } state_t;

  state_t            state;
  logic [WD_W-1:0]   wd_count;
  logic [STAGES-1:0] cur_mask;
  logic              cur_done;
  logic              stray_done;
  logic              last_stage;
  logic [7:0]        pass_next;
  logic              pass_done;
  logic              wd_expire;

  assign active = (state != IDLE);

  // Classify incoming done pulses and precompute the pass / watchdog decisions.
  always_comb begin
    cur_mask   = STAGES'(1) << stage_index;
    cur_done   = (state == RUN) && ((stage_done & cur_mask) != '0);
    stray_done = (state == RUN) ? ((stage_done & ~cur_mask) != '0)
                                : (stage_done != '0);
    last_stage = (int'(stage_index) == STAGES - 1);
    pass_next  = (pass_count == 8'hFF) ? pass_count : pass_count + 8'd1;
    pass_done  = (REPEAT_COUNT != 0) && (int'(pass_next) == REPEAT_COUNT);
    wd_expire  = (TIMEOUT_CYCLES != 0) && ((int'(wd_count) + 1) == TIMEOUT_CYCLES);
  end

  // Show the active stage's value on the LEDs only while that stage is enabled.
  always_comb begin
    led = '0;
    if (active && stage_enabled[stage_index]) begin
      led = stage_value[int'(stage_index)*VALUE_WIDTH +: VALUE_WIDTH];
    end
  end

  // Sequencer state machine; start and seq_done are single-cycle pulses that
  // default low every cycle, and a stray done marks error without stopping.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      stage_start <= '0;
      stage_index <= '0;
      pass_count  <= '0;
      error       <= 1'b0;
      seq_done    <= 1'b0;
      wd_count    <= '0;
    end else begin
      stage_start <= '0;
      seq_done    <= 1'b0;
      if (stray_done) begin
        error <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (go && !halt) begin
            error       <= stray_done;
            pass_count  <= '0;
            stage_index <= '0;
            state       <= LAUNCH;
          end
        end
        LAUNCH: begin
          if (halt) begin
            state <= IDLE;
          end else begin
            stage_start <= cur_mask;
            wd_count    <= '0;
            state       <= RUN;
          end
        end
        RUN: begin
          if (halt) begin
            state <= IDLE;
          end else if (cur_done) begin
            if (!last_stage) begin
              stage_index <= stage_index + IDX_W'(1);
              state       <= LAUNCH;
            end else begin
              pass_count <= pass_next;
              if (pass_done) begin
                seq_done <= 1'b1;
                state    <= IDLE;
              end else begin
                stage_index <= '0;
                state       <= LAUNCH;
              end
            end
          end else if (wd_expire) begin
            error <= 1'b1;
            state <= IDLE;
          end else begin
            wd_count <= wd_count + WD_W'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stage_sequencer.sv
// tb_stage_sequencer
// Randomized bench for stage_sequencer. Bench-side stage models answer each
// expected start with a done after a random latency, and a rule-level model
// predicts every output once per cycle.
module tb_stage_sequencer;

  localparam int S  = 2;
  localparam int W  = 4;
  localparam int R  = 3;
  localparam int T  = 8;
  localparam int IW = (S > 1) ? $clog2(S) : 1;

  logic           clock = 1'b0;
  logic           reset;
  logic           go;
  logic           halt;
  logic [S-1:0]   stage_start;
  logic [S-1:0]   stage_done;
  logic [S-1:0]   stage_enabled;
  logic [S*W-1:0] stage_value;
  logic [W-1:0]   led;
  logic           active;
  logic [IW-1:0]  stage_index;
  logic [7:0]     pass_count;
  logic           error;
  logic           seq_done;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: what the sequencer should be showing right now.
  bit m_known;
  bit m_busy;
  bit m_pending;
  bit m_err;
  bit m_seq;
  int m_idx;
  int m_pass;
  int m_start;
  int m_wait;

  // Stage models: cycles until each stage answers; 0 means no answer pending.
  int         cd [S];
  int         lat_lo;
  int         lat_hi;
  bit         halt_with_done;
  logic [W-1:0] vals [S];

  stage_sequencer #(
    .STAGES(S),
    .VALUE_WIDTH(W),
    .REPEAT_COUNT(R),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clock(clock),
    .reset(reset),
    .go(go),
    .halt(halt),
    .stage_start(stage_start),
    .stage_done(stage_done),
    .stage_enabled(stage_enabled),
    .stage_value(stage_value),
    .led(led),
    .active(active),
    .stage_index(stage_index),
    .pass_count(pass_count),
    .error(error),
    .seq_done(seq_done)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkAll();
    logic [31:0] exp_led;
    logic [31:0] exp_start;
    exp_led   = (m_busy && stage_enabled[m_idx]) ? 32'(vals[m_idx]) : 32'd0;
    exp_start = (m_start >= 0) ? (32'd1 << m_start) : 32'd0;
    checkOutput("active",      32'(active),      32'(m_busy));
    checkOutput("stage_start", 32'(stage_start), exp_start);
    checkOutput("stage_index", 32'(stage_index), 32'(m_idx));
    checkOutput("pass_count",  32'(pass_count),  32'(m_pass));
    checkOutput("error",       32'(error),       32'(m_err));
    checkOutput("seq_done",    32'(seq_done),    32'(m_seq));
    checkOutput("led",         32'(led),         exp_led);
  endtask

  task automatic modelReset();
    m_known   = 1'b1;
    m_busy    = 1'b0;
    m_pending = 1'b0;
    m_err     = 1'b0;
    m_seq     = 1'b0;
    m_idx     = 0;
    m_pass    = 0;
    m_start   = -1;
    m_wait    = 0;
    for (int i = 0; i < S; i++) cd[i] = 0;
  endtask

  // Apply the sequencing rules for one rising edge.
  task automatic modelStep(input bit go_i, input bit halt_i, input logic [S-1:0] done_i);
    int n_start;
    bit n_seq;
    bit stray;
    n_start = -1;
    n_seq   = 1'b0;
    stray   = 1'b0;
    for (int j = 0; j < S; j++) begin
      if (done_i[j] && !(m_busy && !m_pending && j == m_idx)) stray = 1'b1;
    end
    if (!m_busy) begin
      if (go_i && !halt_i) begin
        m_err     = 1'b0;
        m_pass    = 0;
        m_idx     = 0;
        m_busy    = 1'b1;
        m_pending = 1'b1;
      end
    end else if (halt_i) begin
      m_busy    = 1'b0;
      m_pending = 1'b0;
    end else if (m_pending) begin
      n_start   = m_idx;
      m_pending = 1'b0;
      m_wait    = 0;
    end else if (done_i[m_idx]) begin
      if (m_idx < S - 1) begin
        m_idx     = m_idx + 1;
        m_pending = 1'b1;
      end else begin
        if (m_pass < 255) m_pass = m_pass + 1;
        if (R != 0 && m_pass == R) begin
          n_seq  = 1'b1;
          m_busy = 1'b0;
        end else begin
          m_idx     = 0;
          m_pending = 1'b1;
        end
      end
    end else begin
      m_wait = m_wait + 1;
      if (T != 0 && m_wait == T) begin
        m_err  = 1'b1;
        m_busy = 1'b0;
      end
    end
    if (stray) m_err = 1'b1;
    m_start = n_start;
    m_seq   = n_seq;
    if (n_start >= 0 && lat_hi > 0) cd[n_start] = $urandom_range(lat_hi, lat_lo) + 1;
  endtask

  // Drive one cycle of inputs at the falling edge, check, then advance the model.
  task automatic applyStimulus(input bit rst_n, input bit go_i, input bit halt_i, input logic [S-1:0] extra);
    logic [S-1:0] d;
    bit           g;
    bit           h;
    @(negedge clock);
    d = extra;
    g = go_i;
    h = halt_i;
    for (int i = 0; i < S; i++) begin
      if (cd[i] > 0) begin
        cd[i] = cd[i] - 1;
        if (cd[i] == 0) d[i] = 1'b1;
      end
    end
    if (halt_with_done && m_busy && !m_pending && d[m_idx]) h = 1'b1;
    if (d != '0) g = 1'b0;
    for (int i = 0; i < S; i++) begin
      vals[i] = W'($urandom);
      stage_value[i*W +: W] = vals[i];
    end
    reset         = rst_n;
    go            = g;
    halt          = h;
    stage_done    = d;
    stage_enabled = S'($urandom);
    #1;
    if (m_known) checkAll();
    if (!rst_n) modelReset();
    else if (m_known) modelStep(g, h, d);
  endtask

  initial begin
    reset          = 1'b0;
    go             = 1'b0;
    halt           = 1'b0;
    stage_done     = '0;
    stage_enabled  = '0;
    stage_value    = '0;
    m_known        = 1'b0;
    m_busy         = 1'b0;
    m_pending      = 1'b0;
    m_err          = 1'b0;
    m_seq          = 1'b0;
    m_idx          = 0;
    m_pass         = 0;
    m_start        = -1;
    m_wait         = 0;
    halt_with_done = 1'b0;
    lat_lo         = 2;
    lat_hi         = 5;
    for (int i = 0; i < S; i++) begin
      cd[i]   = 0;
      vals[i] = '0;
    end

    // Reset held with go asserted, then release.
    repeat (2) applyStimulus(1'b0, 1'b1, 1'b0, '0);
    repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, '0);

    // Clean looping run of REPEAT_COUNT passes.
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    repeat (60) applyStimulus(1'b1, 1'b0, 1'b0, '0);

    // go held high while active, then let the sequence settle.
    repeat (30) applyStimulus(1'b1, 1'b1, 1'b0, '0);
    repeat (60) applyStimulus(1'b1, 1'b0, 1'b0, '0);

    // Stage 0 never answers: watchdog fires.
    lat_hi = 0;
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    repeat (15) applyStimulus(1'b1, 1'b0, 1'b0, '0);

    // A new go clears error; a stray done from stage 1 while stage 0 runs.
    lat_lo = 2;
    lat_hi = 5;
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b10);
    repeat (60) applyStimulus(1'b1, 1'b0, 1'b0, '0);

    // halt on the same edge as the first stage done.
    halt_with_done = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    repeat (20) applyStimulus(1'b1, 1'b0, 1'b0, '0);
    halt_with_done = 1'b0;

    // Reset in the middle of a run.
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    repeat (6) applyStimulus(1'b1, 1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    repeat (5) applyStimulus(1'b1, 1'b0, 1'b0, '0);

    // Random traffic: latencies straddle the watchdog limit.
    lat_lo = 1;
    lat_hi = 10;
    repeat (3000) begin
      bit           r_n;
      bit           g;
      bit           h;
      logic [S-1:0] x;
      r_n = ($urandom_range(299, 0) != 0);
      h   = ($urandom_range(39, 0) == 0);
      g   = m_busy ? ($urandom_range(5, 0) == 0) : ($urandom_range(3, 0) == 0);
      x   = '0;
      if ($urandom_range(29, 0) == 0) x[$urandom_range(S - 1, 0)] = 1'b1;
      applyStimulus(r_n, g, h, x);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
